// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants: default 640x480@60 raster, derived totals,
// sync window positions and the coordinate width used by every counter.
package vga_timing_pkg;

   localparam int COORD_W   = 10;
   localparam int MAX_TOTAL = 1 << COORD_W;

   typedef logic [COORD_W-1:0] coord_t;

   // Default 640x480@60 horizontal timing, in pixels
   localparam int DEF_H_VISIBLE = 640;
   localparam int DEF_H_FRONT   = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BACK    = 48;

   // Default 640x480@60 vertical timing, in lines
   localparam int DEF_V_VISIBLE = 480;
   localparam int DEF_V_FRONT   = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BACK    = 33;

   localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
   localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

   // Sync windows are inclusive [start, end] coordinate ranges
   localparam int DEF_HS_START = DEF_H_VISIBLE + DEF_H_FRONT;
   localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC - 1;
   localparam int DEF_VS_START = DEF_V_VISIBLE + DEF_V_FRONT;
   localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC - 1;

   // True when value lies in the inclusive window [first, last]
   function automatic logic in_span(coord_t value, coord_t first, coord_t last);
      return (value >= first) && (value <= last);
   endfunction

endpackage

// File: rtl/vga_timing_frame_tick_mod_counter.sv
// Modulo-N up counter with a look-ahead next value and a combinational wrap
// strobe, so a following counter can chain on wrap within the same edge.
module mod_counter #(
   parameter int MODULUS = 2,
   parameter int WIDTH   = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] nextCount,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

   logic at_last;

   assign at_last = (count == LAST);
   assign wrap    = inc && at_last;

   // Value the counter takes on the coming edge
   always_comb begin
      // NOTE: default first so every path assigns nextCount and no latch is inferred.
      nextCount = count;
      if (inc) begin
         nextCount = at_last ? '0 : count + WIDTH'(1);
      end
   end

   // Count register
   always_ff @(posedge clock or posedge reset) begin
      // NOTE: non-blocking assignments for state so all flops update together at the edge.
      if (reset) begin
         count <= '0;
      end else begin
         count <= nextCount;
      end
   end

endmodule

// File: rtl/vga_timing_frame_tick.sv
// VGA raster timing generator with a frame-rate tick. Sync and visible decode
// is taken from the counters' next values and registered alongside them, so the
// decoded outputs line up with hPos/vPos in every cycle with no extra latency.
module vga_timing_frame_tick
   import vga_timing_pkg::*;
#(
   parameter int H_VISIBLE       = DEF_H_VISIBLE,
   parameter int H_FRONT         = DEF_H_FRONT,
   parameter int H_SYNC          = DEF_H_SYNC,
   parameter int H_BACK          = DEF_H_BACK,
   parameter int V_VISIBLE       = DEF_V_VISIBLE,
   parameter int V_FRONT         = DEF_V_FRONT,
   parameter int V_SYNC          = DEF_V_SYNC,
   parameter int V_BACK          = DEF_V_BACK,
   parameter bit SYNC_ACTIVE     = 1'b0,
   parameter int FRAMES_PER_STEP = 30
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               pixelEnable,
   output logic               hsync,
   output logic               vsync,
   output logic               videoOn,
   output logic [COORD_W-1:0] hPos,
   output logic [COORD_W-1:0] vPos,
   output logic               frameTick
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int FRAME_W = $clog2(FRAMES_PER_STEP + 1);

   localparam coord_t HS_FIRST = coord_t'(H_VISIBLE + H_FRONT);
   localparam coord_t HS_LAST  = coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam coord_t VS_FIRST = coord_t'(V_VISIBLE + V_FRONT);
   localparam coord_t VS_LAST  = coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);
   localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
   localparam coord_t V_VIS    = coord_t'(V_VISIBLE);

   // Refuse to build configurations the 10-bit coordinates cannot represent
   if (H_TOTAL > MAX_TOTAL) begin : g_h_total_too_big
      $error("H_TOTAL exceeds the coordinate range");
   end
   if (V_TOTAL > MAX_TOTAL) begin : g_v_total_too_big
      $error("V_TOTAL exceeds the coordinate range");
   end
   if (FRAMES_PER_STEP < 1) begin : g_frames_per_step_illegal
      $error("FRAMES_PER_STEP must be at least 1");
   end

   coord_t               h_count, h_next;
   coord_t               v_count, v_next;
   logic [FRAME_W-1:0]   frame_count, frame_next;
   logic                 h_wrap, v_wrap, frame_wrap;
   logic                 started, started_next;

   // Horizontal position advances on every pixel strobe
   mod_counter #(.MODULUS(H_TOTAL), .WIDTH(COORD_W)) u_h_counter (
      .clock     (clock),
      .reset     (reset),
      .inc       (pixelEnable),
      .count     (h_count),
      .nextCount (h_next),
      .wrap      (h_wrap)
   );

   // Vertical position advances when the line wraps
   mod_counter #(.MODULUS(V_TOTAL), .WIDTH(COORD_W)) u_v_counter (
      .clock     (clock),
      .reset     (reset),
      .inc       (h_wrap),
      .count     (v_count),
      .nextCount (v_next),
      .wrap      (v_wrap)
   );

   // Frame count advances at end of frame; its wrap is the tick condition
   mod_counter #(.MODULUS(FRAMES_PER_STEP), .WIDTH(FRAME_W)) u_frame_counter (
      .clock     (clock),
      .reset     (reset),
      .inc       (v_wrap),
      .count     (frame_count),
      .nextCount (frame_next),
      .wrap      (frame_wrap)
   );

   // Frame count value itself is not needed outside the counter
   logic unused_frame;
   assign unused_frame = ^{frame_count, frame_next};

   assign started_next = started | pixelEnable;
   assign hPos         = h_count;
   assign vPos         = v_count;

   // Register sync, visible and tick decodes in step with the position counters
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         started   <= 1'b0;
         hsync     <= ~SYNC_ACTIVE;
         vsync     <= ~SYNC_ACTIVE;
         videoOn   <= 1'b0;
         frameTick <= 1'b0;
      end else begin
         started   <= started_next;
         hsync     <= in_span(h_next, HS_FIRST, HS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         vsync     <= in_span(v_next, VS_FIRST, VS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         videoOn   <= started_next && (h_next < H_VIS) && (v_next < V_VIS);
         frameTick <= frame_wrap;
      end
   end

endmodule

// File: tb/tb_vga_timing_frame_tick.sv
// Self-checking bench for vga_timing_frame_tick. Four instances cover the
// default raster, a short-line/full-height raster, and two tiny rasters with
// different frame-tick ratios. A behavioural model pushes expected outputs to
// a scoreboard queue as each cycle is driven; they are popped and compared
// once the DUT has produced that cycle's outputs.
module tb_vga_timing_frame_tick;

   localparam int NI = 4;
   localparam logic [23:0] RESET_VAL = {1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 10'd0};

   typedef struct {
      int hv, hf, hs, hb;
      int vv, vf, vs, vb;
      int fps;
   } cfg_t;

   logic       clock = 1'b0;
   logic       rst [NI];
   logic       pe  [NI];
   logic       hs  [NI];
   logic       vs  [NI];
   logic       vo  [NI];
   logic       ft  [NI];
   logic [9:0] hp  [NI];
   logic [9:0] vp  [NI];

   int   checks = 0;
   int   errors = 0;
   cfg_t cfg [NI];
   int   m_h [NI];
   int   m_v [NI];
   int   m_f [NI];
   bit   m_st[NI];
   logic [23:0] exp_q[$];

   always #5 clock = ~clock;

   vga_timing_frame_tick u_def (
      .clock(clock), .reset(rst[0]), .pixelEnable(pe[0]), .hsync(hs[0]), .vsync(vs[0]),
      .videoOn(vo[0]), .hPos(hp[0]), .vPos(vp[0]), .frameTick(ft[0]));

   vga_timing_frame_tick #(.H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(2),
                           .FRAMES_PER_STEP(1)) u_tall (
      .clock(clock), .reset(rst[1]), .pixelEnable(pe[1]), .hsync(hs[1]), .vsync(vs[1]),
      .videoOn(vo[1]), .hPos(hp[1]), .vPos(vp[1]), .frameTick(ft[1]));

   vga_timing_frame_tick #(.H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(2),
                           .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                           .FRAMES_PER_STEP(3)) u_s3 (
      .clock(clock), .reset(rst[2]), .pixelEnable(pe[2]), .hsync(hs[2]), .vsync(vs[2]),
      .videoOn(vo[2]), .hPos(hp[2]), .vPos(vp[2]), .frameTick(ft[2]));

   vga_timing_frame_tick #(.H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(2),
                           .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                           .FRAMES_PER_STEP(1)) u_s1 (
      .clock(clock), .reset(rst[3]), .pixelEnable(pe[3]), .hsync(hs[3]), .vsync(vs[3]),
      .videoOn(vo[3]), .hPos(hp[3]), .vPos(vp[3]), .frameTick(ft[3]));

   task automatic check(input string tag, input logic [23:0] got, input logic [23:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", tag, got, expv);
      end
   endtask

   function automatic logic [23:0] obs(input int i);
      return {ft[i], vo[i], vs[i], hs[i], vp[i], hp[i]};
   endfunction

   function automatic void model_reset(input int i);
      m_h[i]  = 0;
      m_v[i]  = 0;
      m_f[i]  = 0;
      m_st[i] = 1'b0;
   endfunction

   // Advance the model by one clock and return the outputs expected after it
   function automatic logic [23:0] model_step(input int i, input bit en);
      int   ht, vt, h, v;
      logic tick, hsy, vsy, vid;
      ht   = cfg[i].hv + cfg[i].hf + cfg[i].hs + cfg[i].hb;
      vt   = cfg[i].vv + cfg[i].vf + cfg[i].vs + cfg[i].vb;
      tick = 1'b0;
      if (en) begin
         m_st[i] = 1'b1;
         if (m_h[i] == ht - 1 && m_v[i] == vt - 1) begin
            if (m_f[i] == cfg[i].fps - 1) begin
               tick   = 1'b1;
               m_f[i] = 0;
            end else begin
               m_f[i] = m_f[i] + 1;
            end
         end
         if (m_h[i] == ht - 1) begin
            m_h[i] = 0;
            m_v[i] = (m_v[i] == vt - 1) ? 0 : m_v[i] + 1;
         end else begin
            m_h[i] = m_h[i] + 1;
         end
      end
      h   = m_h[i];
      v   = m_v[i];
      hsy = (h >= cfg[i].hv + cfg[i].hf && h < cfg[i].hv + cfg[i].hf + cfg[i].hs) ? 1'b0 : 1'b1;
      vsy = (v >= cfg[i].vv + cfg[i].vf && v < cfg[i].vv + cfg[i].vf + cfg[i].vs) ? 1'b0 : 1'b1;
      vid = m_st[i] && (h < cfg[i].hv) && (v < cfg[i].vv);
      return {tick, vid, vsy, hsy, 10'(v), 10'(h)};
   endfunction

   // Drive one clock on instance i and score its outputs after the edge
   task automatic drive(input int i, input bit en);
      pe[i] = en;
      exp_q.push_back(model_step(i, en));
      @(posedge clock);
      #1;
      pe[i] = 1'b0;
      check($sformatf("cycle_u%0d", i), obs(i), exp_q.pop_front());
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int en_n, hs_low, vid1, vs_low, vs_min, vs_max, first_tick;
      int npulse, run, maxrun, tick_at, pp, k, last;
      int pulse_at[3];
      int pp_exp[15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
      bit en, up;

      cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 30};
      cfg[1] = '{4, 1, 1, 2, 480, 10, 2, 33, 1};
      cfg[2] = '{4, 1, 1, 2, 3, 1, 1, 1, 3};
      cfg[3] = '{4, 1, 1, 2, 3, 1, 1, 1, 1};
      for (int i = 0; i < NI; i++) begin
         rst[i] = 1'b1;
         pe[i]  = 1'b0;
         model_reset(i);
      end

      // Reset hold on every instance, then idle clocks with no pixel strobe
      repeat (3) @(posedge clock);
      #1;
      for (int i = 0; i < NI; i++) check($sformatf("reset_hold_u%0d", i), obs(i), RESET_VAL);
      rst[0] = 1'b0;
      repeat (20) drive(0, 1'b0);

      // Two default lines with the strobe on every other clock
      en_n   = 0;
      hs_low = 0;
      vid1   = 0;
      for (int c = 0; c < 3200; c++) begin
         en = (c % 2 == 0);
         drive(0, en);
         if (en) begin
            en_n++;
            if (vp[0] == 10'd0 && !hs[0]) hs_low++;
            if (vp[0] == 10'd1 && vo[0]) vid1++;
            if (en_n == 800) check("line_wrap", 24'({vp[0], hp[0]}), 24'({10'd1, 10'd0}));
         end
      end
      check("hsync_low_count", 24'(hs_low), 24'(96));
      check("video_line1_count", 24'(vid1), 24'(640));

      // Full frame on the short-line raster with default vertical timing
      rst[1]     = 1'b0;
      vs_low     = 0;
      vs_min     = 1023;
      vs_max     = 0;
      first_tick = -1;
      for (int c = 1; c <= 4210; c++) begin
         drive(1, 1'b1);
         if (!vs[1]) begin
            vs_low++;
            if (int'(vp[1]) < vs_min) vs_min = int'(vp[1]);
            if (int'(vp[1]) > vs_max) vs_max = int'(vp[1]);
         end
         if (ft[1] && first_tick < 0) first_tick = c;
      end
      check("vsync_low_count", 24'(vs_low), 24'(16));
      check("vsync_first_line", 24'(vs_min), 24'(490));
      check("vsync_last_line", 24'(vs_max), 24'(491));
      check("end_of_frame_enable", 24'(first_tick), 24'(4200));

      // Random strobe, tick every third 48-pixel frame
      rst[2] = 1'b0;
      en_n   = 0;
      npulse = 0;
      run    = 0;
      maxrun = 0;
      for (int c = 0; c < 3000 && en_n < 432; c++) begin
         en = 1'($urandom_range(0, 1));
         drive(2, en);
         if (en) en_n++;
         if (ft[2]) begin
            run++;
            if (run == 1) begin
               if (npulse < 3) pulse_at[npulse] = en_n;
               npulse++;
               check("tick_at_origin", 24'({vp[2], hp[2]}), 24'(0));
            end
         end else begin
            run = 0;
         end
         if (run > maxrun) maxrun = run;
      end
      for (int c = 0; c < 4; c++) begin
         drive(2, c[0]);
         if (ft[2]) run++;
         else run = 0;
         if (run > maxrun) maxrun = run;
      end
      check("tick_count", 24'(npulse), 24'(3));
      for (int p = 0; p < 3; p++) check($sformatf("tick_enable_%0d", p), 24'(pulse_at[p]), 24'(144 * (p + 1)));
      check("tick_width", 24'(maxrun), 24'(1));

      // Asynchronous reset mid-line at hPos=5, vPos=3, frame count 2
      rst[2] = 1'b1;
      model_reset(2);
      @(posedge clock);
      #1;
      rst[2] = 1'b0;
      repeat (125) drive(2, 1'b1);
      check("pre_reset_pos", 24'({vp[2], hp[2]}), 24'({10'd3, 10'd5}));
      #3;
      rst[2] = 1'b1;
      model_reset(2);
      #1;
      check("async_reset", obs(2), RESET_VAL);
      @(posedge clock);
      #1;
      rst[2]  = 1'b0;
      tick_at = -1;
      for (int c = 1; c <= 200; c++) begin
         drive(2, 1'b1);
         if (ft[2]) begin
            tick_at = c;
            break;
         end
      end
      check("tick_after_reset", 24'(tick_at), 24'(144));

      // Tick every frame feeding a downstream 3-bit ping-pong counter
      rst[3] = 1'b0;
      pp     = 0;
      up     = 1'b1;
      k      = 0;
      last   = 0;
      for (int c = 1; c <= 730; c++) begin
         drive(3, 1'b1);
         if (ft[3]) begin
            check("tick_gap", 24'(c - last), 24'(48));
            last = c;
            if (up) begin
               if (pp == 7) begin
                  up = 1'b0;
                  pp = 6;
               end else begin
                  pp++;
               end
            end else begin
               if (pp == 0) begin
                  up = 1'b1;
                  pp = 1;
               end else begin
                  pp--;
               end
            end
            if (k < 15) check($sformatf("pingpong_%0d", k), 24'(pp), 24'(pp_exp[k]));
            k++;
         end
      end
      check("pingpong_ticks", 24'(k), 24'(15));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_timing_frame_tick.md
Name: vga_timing_frame_tick

Overview:
Generates VGA raster timing (hsync, vsync, visible-area flag, pixel coordinates) from a single system clock gated by a pixel-rate enable. Also emits frameTick, a single-clock pulse every FRAMES_PER_STEP frames. frameTick drives the enable input of the downstream 3-bit ping-pong up/down counter that steps the colour/pattern index. This is the stage directly upstream of that counter.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low)
FRAMES_PER_STEP, 30, frames between frameTick pulses; legal range is >= 1

Ports:
clock  input  1  system clock; the only clock
reset  input  1  asynchronous, active-high reset
pixelEnable  input  1  one-clock strobe at pixel rate; all counters advance only when it is 1
hsync  output  1  horizontal sync, level set by SYNC_ACTIVE
vsync  output  1  vertical sync, level set by SYNC_ACTIVE
videoOn  output  1  1 while the current pixel is in the visible area
hPos  output  10  current column, 0..H_TOTAL-1
vPos  output  10  current line, 0..V_TOTAL-1
frameTick  output  1  one-clock pulse every FRAMES_PER_STEP completed frames

Behaviour:
- Derived values: H_TOTAL = sum of the four H_* parameters (800 by default); V_TOTAL = sum of the four V_* parameters (525 by default). Elaboration fails if H_TOTAL > 1024 or V_TOTAL > 1024.
- All outputs are flop outputs. No combinational path runs from any input to any output.
- Reset (asynchronous, any time, including mid-frame): hPos=0, vPos=0, frame count=0, started=0. hsync and vsync go to their inactive level (~SYNC_ACTIVE). videoOn=0, frameTick=0.
- pixelEnable=0: every register holds, and frameTick is forced to 0.
- pixelEnable=1, horizontal: hPos increments; from H_TOTAL-1 it wraps to 0.
- pixelEnable=1, vertical: vPos increments only on the hPos wrap; from V_TOTAL-1 it wraps to 0 on that same edge.
- Sync and visible decode is zero-latency relative to the hPos/vPos outputs. It is computed from the next-count values and registered together with them. So in every cycle:
  hsync == SYNC_ACTIVE iff hPos is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]; default 656..751.
  vsync == SYNC_ACTIVE iff vPos is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1]; default 490..491.
  videoOn == started && hPos < H_VISIBLE && vPos < V_VISIBLE.
- started: set on the first pixelEnable after reset, then stays at 1. Its only purpose is to blank videoOn while in reset and immediately after it.
- End of frame: a pixelEnable edge where hPos=H_TOTAL-1 and vPos=V_TOTAL-1.
- Frame counter: increments at each end of frame.
- frameTick: when an end of frame occurs with frame count = FRAMES_PER_STEP-1, frameTick=1 for exactly the next clock cycle and the frame count returns to 0. That cycle coincides with hPos=0, vPos=0.
- frameTick is 0 in all other cycles. This keeps it glitch-free for use as an edge-sensitive enable downstream. Between pulses, frameTick stays low for at least one clock.
- FRAMES_PER_STEP=1: frameTick pulses at every end of frame.
- First pulse timing: the first frame after reset counts as frame 0, so the first frameTick follows FRAMES_PER_STEP complete frames.
- Frame counter width: $clog2(FRAMES_PER_STEP+1) bits. It never exceeds FRAMES_PER_STEP-1.

Decomposition:
- Shared package vga_timing_pkg holds:
  default 640x480@60 timing constants;
  derived H_TOTAL, V_TOTAL and sync start/end positions;
  the 10-bit coordinate width constant.
- One natural sub-module, mod_counter (parameters MODULUS, WIDTH), instantiated three times: horizontal, vertical, frame.
  Inputs: clock, reset, inc.
  Outputs: count, nextCount, wrap.
  wrap is combinational and equals inc && count==MODULUS-1.

Test Plan:
1. Reset hold, then release with pixelEnable=0 for 20 clocks -> hPos=vPos=0; hsync=vsync=1 (SYNC_ACTIVE=0); videoOn=0; frameTick=0 throughout.
2. Defaults, pixelEnable high every other clock, run one line -> hsync low exactly for hPos 656..751 (96 enables). videoOn high for hPos 0..639 on vPos 0. hPos wraps 799->0 and vPos goes to 1 on that same edge.
3. Defaults, one full frame -> vsync low exactly while vPos is 490..491. The end of frame occurs at the 420000th enable.
4. FRAMES_PER_STEP=3 with small timing (H 4/1/1/2, V 3/1/1/1; totals 8x6) -> frameTick pulses at enables 144, 288 and 432 after reset. Each pulse is one clock wide and coincides with hPos=vPos=0. Checker counts pulses and widths.
5. FRAMES_PER_STEP=1, small timing, pixelEnable tied high -> frameTick every 48 clocks. A model of the downstream 3-bit ping-pong counter fed by frameTick yields 1,2,3,4,5,6,7,6,5,...
6. Assert reset mid-line (hPos=5, vPos=3, frame count=2), then release -> all outputs return to reset values asynchronously, before the next clock edge. The next frameTick arrives a full FRAMES_PER_STEP frames after release.
